// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response handshake bundle between two requesters and the shared ALU arbiter.
interface alu_arbiter_if #(parameter int WIDTH = 8);
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [15:0] req0_op, req1_op;
  logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [WIDTH:0] rsp_res;
  logic rsp_err, busy;
  modport master(
    output req0_valid, req0_a, req0_b, req0_op, req1_valid, req1_a, req1_b, req1_op, rsp0_ready, rsp1_ready,
    input req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_res, rsp_err, busy
  );
  modport slave(
    input req0_valid, req0_a, req0_b, req0_op, req1_valid, req1_a, req1_b, req1_op, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_res, rsp_err, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front-end sharing one alu; IDLE/EXEC/RESP, one transaction in flight.
// Define ALU_ARB_RR_EN for round-robin conflict resolution; otherwise requester 0 has fixed priority.
module alu #(parameter int largo = 8) (
  input  logic [largo-1:0] a,
  input  logic [largo-1:0] b,
  input  logic [15:0]      op,
  output logic [largo:0]   res,
  output logic             err
);
  logic [largo:0] ea, eb;
  always_comb begin
    ea = {1'b0, a};
    eb = {1'b0, b};
    res = op == 16'd16 ? ea + eb :
          op == 16'd17 ? ea * eb :
          op == 16'd18 ? ea & eb :
          op == 16'd20 ? ea - eb :
          op == 16'd21 ? ea | eb : '0;
    err = !(op inside {16'd16, 16'd17, 16'd18, 16'd20, 16'd21});
  end
endmodule

module alu_arbiter #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [15:0] op_q;
  logic [WIDTH:0] res_q, alu_res;
  logic gid, err_q, alu_err, busy_q, win1, hs, rsp_hs;
`ifdef ALU_ARB_RR_EN
  logic last_grant;
  always_comb win1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_grant <= 1'b1;
    else if (hs) last_grant <= win1;
`else
  always_comb win1 = bus.req1_valid && !bus.req0_valid;
`endif
  alu #(.largo(WIDTH)) u_alu (.a(a_q), .b(b_q), .op(op_q), .res(alu_res), .err(alu_err));
  // rst_n gating keeps both readies low while reset is held, even with valids up
  always_comb begin
    bus.req0_ready = rst_n && state == IDLE && bus.req0_valid && !win1;
    bus.req1_ready = rst_n && state == IDLE && win1;
    hs = bus.req0_ready || bus.req1_ready;
    rsp_hs = gid ? bus.rsp1_ready : bus.rsp0_ready;
    state_d = state == IDLE ? (hs ? EXEC : IDLE) :
              state == EXEC ? RESP : (rsp_hs ? IDLE : RESP);
    bus.rsp0_valid = state == RESP && !gid;
    bus.rsp1_valid = state == RESP && gid;
    bus.rsp_res = res_q;
    bus.rsp_err = err_q;
    bus.busy = busy_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      gid <= 1'b0;
      res_q <= '0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state <= state_d;
      busy_q <= state_d != IDLE;
      if (hs) begin
        a_q <= win1 ? bus.req1_a : bus.req0_a;
        b_q <= win1 ? bus.req1_b : bus.req0_b;
        op_q <= win1 ? bus.req1_op : bus.req0_op;
        gid <= win1;
      end
      if (state == EXEC) begin
        res_q <= alu_res;
        err_q <= alu_err;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a transaction-level model.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int last = 1;
  alu_arbiter_if #(.WIDTH(8)) bus();
  alu_arbiter #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] model(input int a, input int b, input int op);
    int r;
    case (op)
      16: r = a + b;
      17: r = a * b;
      18: r = a & b;
      20: r = a - b;
      21: r = a | b;
      default: return {1'b1, 9'd0};
    endcase
    return {1'b0, r[8:0]};
  endfunction

  function automatic int pick(input bit v0, input bit v1);
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
`ifdef ALU_ARB_RR_EN
    return last == 1 ? 0 : 1;
`else
    return 0;
`endif
  endfunction

  task automatic outputs_zero(input string tag);
    check({tag, "_rdy0"}, bus.req0_ready, 0);
    check({tag, "_rdy1"}, bus.req1_ready, 0);
    check({tag, "_rv0"}, bus.rsp0_valid, 0);
    check({tag, "_rv1"}, bus.rsp1_valid, 0);
    check({tag, "_res"}, bus.rsp_res, 0);
    check({tag, "_err"}, bus.rsp_err, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic txn(input string tag, input bit v0, input bit v1,
                     input logic [7:0] a0, input logic [7:0] b0, input logic [15:0] o0,
                     input logic [7:0] a1, input logic [7:0] b1, input logic [15:0] o1, input int hold);
    int w;
    logic [9:0] e;
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = o0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = o1;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    #1;
    w = pick(v0, v1);
    e = w ? model(a1, b1, o1) : model(a0, b0, o0);
`ifdef ALU_ARB_RR_EN
    last = w;
`endif
    check({tag, "_rdy0"}, bus.req0_ready, w == 0);
    check({tag, "_rdy1"}, bus.req1_ready, w == 1);
    @(posedge clk); #1;
    check({tag, "_exec_busy"}, bus.busy, 1);
    check({tag, "_exec_rv"}, {bus.rsp1_valid, bus.rsp0_valid}, 0);
    check({tag, "_exec_rdy"}, {bus.req1_ready, bus.req0_ready}, 0);
    if (w == 1) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i <= hold; i++) begin
      check({tag, "_rv0"}, bus.rsp0_valid, w == 0);
      check({tag, "_rv1"}, bus.rsp1_valid, w == 1);
      check({tag, "_res"}, bus.rsp_res, e[8:0]);
      check({tag, "_err"}, bus.rsp_err, e[9]);
      check({tag, "_resp_busy"}, bus.busy, 1);
      check({tag, "_resp_rdy"}, {bus.req1_ready, bus.req0_ready}, 0);
      if (i == hold) begin
        if (w == 1) bus.rsp1_ready = 1'b1; else bus.rsp0_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    check({tag, "_done_busy"}, bus.busy, 0);
    check({tag, "_done_rv"}, {bus.rsp1_valid, bus.rsp0_valid}, 0);
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  initial begin
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    outputs_zero("reset");
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn("add", 1, 0, 8'd200, 8'd100, 16'd16, 8'd0, 8'd0, 16'd0, 0);
    txn("sub", 0, 1, 8'd0, 8'd0, 16'd0, 8'd3, 8'd5, 16'd20, 0);
    txn("mul", 0, 1, 8'd0, 8'd0, 16'd0, 8'hFF, 8'hFF, 16'd17, 0);
    txn("badop", 1, 1, 8'd7, 8'd9, 16'd19, 8'd1, 8'd2, 16'd19, 5);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_a = 8'd1; bus.req0_b = 8'd2; bus.req0_op = 16'd16;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    check("rst_in_exec", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    outputs_zero("rst_mid");
    last = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_no_rsp", {bus.rsp1_valid, bus.rsp0_valid, bus.busy}, 0);
    end
    for (int i = 0; i < 4; i++)
      txn("conflict", 1, 1, 8'd10 + 8'(i), 8'd3, 16'd16, 8'd20 + 8'(i), 8'd4, 16'd20, 0);
    for (int i = 0; i < 24; i++) begin
      logic [15:0] ops [6];
      int s;
      ops = '{16'd16, 16'd17, 16'd18, 16'd20, 16'd21, 16'd16};
      ops[5] = 16'($urandom);
      s = $urandom_range(1, 3);
      txn("rand", s[0], s[1], 8'($urandom), 8'($urandom), ops[$urandom_range(0, 5)],
          8'($urandom), 8'($urandom), ops[$urandom_range(0, 5)], $urandom_range(0, 3));
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencing front-end for the shared `alu` datapath. Two requesters submit operand/opcode transactions over valid/ready handshakes. The arbiter grants one of them, latches its operands, drives one `alu` instance and returns the registered result to the granted requester over a response handshake. It sits between the control units (keypad/FSM front-ends) and the single ALU, so that both can use it without contention.

## Interface
- `WIDTH`, default 8: operand width; passed to `alu` as `largo`.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has a transaction.
- `req0_ready`  out  1  requester 0 transaction accepted this cycle.
- `req0_a`  in  WIDTH  operand A, requester 0.
- `req0_b`  in  WIDTH  operand B, requester 0.
- `req0_op`  in  16  opcode, requester 0.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as the requester 0 ports, for requester 1.
- `rsp0_valid`  out  1  result available for requester 0.
- `rsp0_ready`  in  1  requester 0 consumes the result.
- `rsp1_valid`, `rsp1_ready`: same as the requester 0 ports, for requester 1.
- `rsp_res`  out  WIDTH+1  result, shared by both responses.
- `rsp_err`  out  1  opcode was unsupported; qualified by rspX_valid.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **Opcodes.** The decimal opcodes match the ALU:
  - 16: add, a+b.
  - 17: multiply, a*b, truncated to WIDTH+1 bits.
  - 18: AND, zero-extended.
  - 20: subtract, a-b, modulo 2^(WIDTH+1). Example: 3-5 at WIDTH=8 gives 9'h1FE.
  - 21: OR, zero-extended.
  - Any other value: result 0 and `rsp_err` = 1.
- **States:**
  - IDLE: accept one request. The next state is EXEC on a handshake, otherwise IDLE.
  - EXEC: operands are held in registers and the ALU evaluates. The result and error flag are registered. The next state is always RESP.
  - RESP: `rspX_valid` is high for the granted requester only, and `rsp_res`/`rsp_err` are held stable. On `rspX_ready` the next state is IDLE; otherwise the state stays RESP.
- **Grant (IDLE only).**
  - If only one valid is high, that requester wins.
  - If both are high, the priority rule in Configuration decides.
  - `reqX_ready` = (state==IDLE) && winner==X. It is combinational from the valid inputs, and at most one ready is high.
- **Latching at the handshake.** Operands, opcode and grant id are latched. Inputs are ignored outside the handshake cycle.
- **Requester obligation.** A requester holds valid and its data stable until it sees ready.
- **No pipelining.** One transaction is in flight at a time. New requests wait while the arbiter is busy.
- **Reset values.** Every output and register is 0 (`req*_ready` = 0, `rsp*_valid` = 0, `rsp_res` = 0, `rsp_err` = 0, `busy` = 0). The state resets to IDLE and `last_grant` resets to 1.
- **Reset mid-transaction.** The transaction is dropped and no response is issued.

## Timing
- **Handshake at edge N.** Edge N registers `valid && ready` and moves the state to EXEC.
- **Edge N+1.** The result is registered and the state moves to RESP. `rspX_valid` is high from N+1 until the edge where `rspX_ready` is sampled high.
- **Minimum latency** from request acceptance to response valid is 1 cycle. The minimum period between accepts is 3 cycles, with immediate `rsp_ready`.
- **Back-to-back.** `rspX_ready` held high returns the state to IDLE at edge N+2. A new accept can occur in the cycle after N+2.
- **Stray response ready.** `rspX_ready` outside RESP, or for the non-granted id, has no effect.
- **`busy`** is registered and equals state != IDLE.

## Configuration
- **`ALU_ARB_RR_EN` defined.** Round-robin arbitration.
  - On a conflict, the requester other than `last_grant` wins.
  - `last_grant` updates at every accept.
  - Reset value 1 means requester 0 wins the first conflict.
- **`ALU_ARB_RR_EN` undefined.** Fixed priority.
  - Requester 0 always wins a conflict.
  - `last_grant` is not implemented.
- Behaviour without a conflict is identical in both builds.

## Test plan
- **Single add.** Requester 0: a=8'd200, b=8'd100, op=16. `req0_ready` is high in IDLE. `rsp0_valid` rises 1 cycle after the accept, with `rsp_res`=9'd300 and `rsp_err`=0. `rsp1_valid` stays 0.
- **Subtract and multiply wrap.** Requester 1: a=3, b=5, op=20 gives `rsp_res`=9'h1FE. Then a=8'hFF, b=8'hFF, op=17 gives `rsp_res`=9'h001 (truncated).
- **Bad opcode and backpressure.** op=16'd19 gives `rsp_res`=0 and `rsp_err`=1. Hold `rsp_ready` low for 5 cycles: valid and data stay stable, and both `req*_ready` stay 0 with both valids high.
- **Conflict.** Both requesters keep valid asserted for 4 transactions.
  - With `ALU_ARB_RR_EN`, grants are 0,1,0,1.
  - Without it, grants are 0,0,0,0.
- **Reset mid-op.** Pulse `rst_n` low while in EXEC. All outputs are 0 immediately, no response follows, and the state is IDLE.
